// File: rtl/aes_ctr_keystream.sv
// CTR-mode wrapper around an AES core: issues counter blocks one at a time,
// holds one keystream block, and XORs it onto a valid/ready 128-bit data stream.
module aes_ctr_keystream #(
  parameter int CTR_W        = 32,
  parameter int CORE_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [0:127] cfg_iv,
  output logic         busy,
  output logic         err,
  output logic         core_start,
  output logic [0:127] core_block,
  input  logic         core_done,
  input  logic [0:127] core_result,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [0:127] din_data,
  input  logic         din_last,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [0:127] dout_data,
  output logic         dout_last,
  output logic [0:127] ctr_o
);

  localparam int            TW   = $clog2(CORE_TIMEOUT + 1);
  localparam int            LO   = 128 - CTR_W;
  localparam logic [TW-1:0] TLIM = TW'(CORE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HAVE, S_DRAIN, S_ERROR
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [0:127]  ctr;
  logic [0:127]  ks;
  logic          ks_valid;
  logic          beat;

  // Only the low CTR_W bits count; the nonce part is carried through untouched.
  function automatic logic [0:127] ctr_inc(input logic [0:127] c);
    logic [0:127] n;
    n = c;
    n[LO +: CTR_W] = c[LO +: CTR_W] + CTR_W'(1);
    return n;
  endfunction

  function automatic logic ctr_wraps(input logic [0:127] c);
    return &c[LO +: CTR_W];
  endfunction

  assign din_ready = (state == S_HAVE) && ks_valid && (!dout_valid || dout_ready);
  assign beat      = din_valid && din_ready;
  assign ctr_o     = ctr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      ctr        <= '0;
      ks_valid   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
      core_block <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
    end else begin
      core_start <= 1'b0;

      // Output register: a new beat may load in the same cycle the old one leaves.
      if (beat) begin
        dout_data  <= din_data ^ ks;
        dout_last  <= din_last;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end

      case (state)
        S_IDLE, S_ERROR: begin
          if (cfg_load) begin
            ctr   <= cfg_iv;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          core_start <= 1'b1;
          core_block <= ctr;
          tcnt       <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (core_done) begin
            ks_valid <= 1'b1;
            state    <= S_HAVE;
          end else if (tcnt == TLIM) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERROR;
          end
        end
        S_HAVE: begin
          if (beat) begin
            ks_valid <= 1'b0;
            ctr      <= ctr_inc(ctr);
            if (din_last) begin
              state <= S_DRAIN;
            end else if (ctr_wraps(ctr)) begin
              // Continuing would reuse a counter value, so stop here.
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERROR;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (!dout_valid || dout_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Keystream holds no control meaning on its own; ks_valid qualifies it.
  always_ff @(posedge clk) begin
    if (state == S_WAIT && core_done) ks <= core_result;
  end

endmodule

// File: tb/tb_aes_ctr_keystream.sv
// Scoreboard bench for aes_ctr_keystream with a stub AES core returning
// known SP800-38A keystream blocks for the reference counter values.
module tb_aes_ctr_keystream;

  localparam logic [127:0] IV1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV1P1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] IV1P2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
  localparam logic [127:0] KS1   = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2   = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] DIN1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] DOUT1 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] DIN2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] DOUT2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] IV2   = 128'h00112233445566778899aabb00000010;
  localparam logic [127:0] IV2P1 = 128'h00112233445566778899aabb00000011;
  localparam logic [127:0] IV2P2 = 128'h00112233445566778899aabb00000012;
  localparam logic [127:0] IV3   = 128'hdeadbeef0123456789abcdefffffffff;
  localparam logic [127:0] IV3W  = 128'hdeadbeef0123456789abcdef00000000;
  localparam logic [127:0] IV4   = 128'h11111111222222223333333344444444;
  localparam logic [127:0] IV5   = 128'h55555555666666667777777788888888;
  localparam logic [127:0] IV6   = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] IV6P1 = 128'h0102030405060708090a0b0c0d0e0f11;
  localparam logic [127:0] IV6P2 = 128'h0102030405060708090a0b0c0d0e0f12;
  localparam logic [127:0] IVX   = 128'hcafebabecafebabecafebabe00000000;

  logic         clk = 1'b0, rst = 1'b0, cfg_load = 1'b0, core_done = 1'b0;
  logic         din_valid = 1'b0, din_last = 1'b0, dout_ready = 1'b1;
  logic [127:0] cfg_iv = '0, core_result = '0, din_data = '0;
  logic         busy, err, core_start, din_ready, dout_valid, dout_last;
  logic [127:0] core_block, dout_data, ctr_o;

  int           total = 0, passed = 0;
  int           core_lat = 2, fake_req = 0;
  bit           core_mute = 1'b0;
  logic [128:0] exp_q[$];
  logic [127:0] start_log[$];

  aes_ctr_keystream #(.CTR_W(32), .CORE_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_iv(cfg_iv),
    .busy(busy), .err(err), .core_start(core_start), .core_block(core_block),
    .core_done(core_done), .core_result(core_result),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .ctr_o(ctr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] stub_ks(input logic [127:0] b);
    if (b == IV1)   return KS1;
    if (b == IV1P1) return KS2;
    return ~b ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [127:0] iv);
    cfg_iv = iv; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic l, input logic [127:0] e);
    int n;
    n = 0;
    din_data = d; din_last = l; din_valid = 1'b1;
    @(negedge clk);
    while (din_ready !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("din_accept", din_ready, 1);
    if (din_ready === 1'b1) exp_q.push_back({l, e});
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (core_start !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    chk(name, core_start, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("busy_drop", busy, 0);
    @(posedge clk); #1;
  endtask

  // Stub core: answers each core_start after core_lat cycles unless muted.
  initial begin
    int fake_seen;
    logic [127:0] blk;
    fake_seen = 0;
    forever begin
      @(negedge clk);
      if (fake_req != fake_seen) begin
        fake_seen = fake_req;
        core_result = 128'h0123456789abcdeffedcba9876543210;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end else if (core_start === 1'b1) begin
        blk = core_block;
        start_log.push_back(blk);
        if (!core_mute) begin
          repeat (core_lat) @(negedge clk);
          core_result = stub_ks(blk);
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
        end
      end
    end
  end

  // Output monitor: every accepted output beat is matched against the queue.
  initial begin
    logic [128:0] e;
    forever begin
      @(negedge clk);
      if (rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL dout_unexpected: got %h expected no output", dout_data);
        end else begin
          e = exp_q.pop_front();
          chk("dout", {dout_last, dout_data}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, n;
    logic [8:0] seen;
    logic [127:0] exp_a;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_core_block", core_block, 0);
    rst = 1'b1;
    tick();

    // Reference vectors and cfg_load -> core_start latency
    base = start_log.size();
    cfg_iv = IV1; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    @(negedge clk);
    chk("lat_no_start_yet", core_start, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_start", core_start, 1);
    chk("lat_block", core_block, IV1);
    @(posedge clk); #1;
    send(DIN1, 1'b0, DOUT1);
    send(DIN2, 1'b1, DOUT2);
    wait_idle();
    chk("t1_block2", start_log[base + 1], IV1P1);
    chk("t1_ctr", ctr_o, IV1P2);
    chk("t1_nstarts", start_log.size() - base, 2);

    // Backpressure
    load(IV2);
    dout_ready = 1'b0;
    exp_a = 128'h11112222333344445555666677778888 ^ stub_ks(IV2);
    send(128'h11112222333344445555666677778888, 1'b0, exp_a);
    din_data = 128'h99990000aaaabbbbccccddddeeeeffff; din_last = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_dout_data", dout_data, exp_a);
      chk("bp_din_ready", din_ready, 0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    send(128'h99990000aaaabbbbccccddddeeeeffff, 1'b0,
         128'h99990000aaaabbbbccccddddeeeeffff ^ stub_ks(IV2P1));
    send(128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1,
         128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f ^ stub_ks(IV2P2));
    wait_idle();
    chk("bp_queue_empty", exp_q.size(), 0);

    // Counter wrap
    core_lat = 1;
    base = start_log.size();
    load(IV3);
    send(128'h00000000ffffffff00000000ffffffff, 1'b0,
         128'h00000000ffffffff00000000ffffffff ^ stub_ks(IV3));
    @(negedge clk);
    chk("wrap_err", err, 1);
    chk("wrap_busy", busy, 0);
    s0 = start_log.size();
    repeat (20) @(negedge clk);
    chk("wrap_no_start", start_log.size(), s0);
    chk("wrap_first_block", start_log[base], IV3);
    chk("wrap_ctr_nonce", ctr_o, IV3W);
    @(posedge clk); #1;

    // Core timeout, then a stray core_done
    core_mute = 1'b1;
    load(IV4);
    chk("to_err_cleared", err, 0);
    wait_start("to_start");
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("to_cycles", n, 15);
    chk("to_busy", busy, 0);
    @(posedge clk); #1;
    fake_req++;
    din_valid = 1'b1; din_data = '1;
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | {5'b0, core_start, dout_valid, din_ready, busy};
    end
    chk("to_late_done_quiet", seen, 0);
    chk("to_err_sticky", err, 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    core_mute = 1'b0;

    // Reset in the middle of WAIT
    core_lat = 6;
    load(IV5);
    chk("rw_err_cleared", err, 0);
    wait_start("rw_start");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    din_valid = 1'b1; din_data = 128'h1234;
    seen = '0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | {busy, err, core_start, din_ready, dout_valid, dout_last,
                     |core_block, |ctr_o, |dout_data};
    end
    chk("rw_all_quiet", seen, 0);
    @(posedge clk); #1;
    din_valid = 1'b0;

    // cfg_load while busy is ignored
    core_lat = 3;
    base = start_log.size();
    load(IV6);
    wait_start("ign_start");
    load(IVX);
    send(128'hfedcba98765432100123456789abcdef, 1'b0,
         128'hfedcba98765432100123456789abcdef ^ stub_ks(IV6));
    send(128'h00000000000000000000000000000001, 1'b1,
         128'h00000000000000000000000000000001 ^ stub_ks(IV6P1));
    wait_idle();
    chk("ign_block0", start_log[base], IV6);
    chk("ign_block1", start_log[base + 1], IV6P1);
    chk("ign_ctr", ctr_o, IV6P2);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
